// File: rtl/m_axi4l_rd_channel.sv
// AXI4-Lite master read channel: issues one AR beat per local request,
// accepts the R beat and returns data/resp with a one-cycle done strobe.
//
// Ports:
//   i_axi_clock, i_axi_aresetn        clock, async active-low reset
//   i_rd_req, i_rd_addr, o_rd_req_ready  local request handshake
//   o_rd_data, o_rd_resp, o_rd_err    held result of the last completed read
//   o_rd_done                         one-cycle completion strobe
//   o_rd_timeout                      transaction outstanding too long
//   o_axi_ar*, i_axi_araddr_ready     AXI AR channel
//   i_axi_r*, o_axi_rdata_ready       AXI R channel
module m_axi4l_rd_channel #(
    parameter int          AXI_DATA_WIDTH = 32,
    parameter int          AXI_ADDR_WIDTH = 4,
    parameter logic [3:0]  AXI_ARCACHE    = 4'b0000,
    parameter logic [2:0]  AXI_ARPROT     = 3'b000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                      i_axi_clock,
    input  logic                      i_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                      i_rd_req,
    output logic                      o_rd_req_ready,
    output logic [AXI_DATA_WIDTH-1:0] o_rd_data,
    output logic [1:0]                o_rd_resp,
    output logic                      o_rd_err,
    output logic                      o_rd_done,
    output logic                      o_rd_timeout,
    output logic [AXI_ADDR_WIDTH-1:0] o_axi_araddr,
    output logic [3:0]                o_axi_arcache,
    output logic [2:0]                o_axi_arprot,
    output logic                      o_axi_araddr_valid,
    input  logic                      i_axi_araddr_ready,
    input  logic [AXI_DATA_WIDTH-1:0] i_axi_rdata,
    input  logic [1:0]                i_axi_rresp,
    input  logic                      i_axi_rdata_valid,
    output logic                      o_axi_rdata_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARADDR,
        S_RDATA,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] data_q;
    logic [1:0]                resp_q;

    always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (i_rd_req)           state_nxt = S_ARADDR;
            S_ARADDR: if (i_axi_araddr_ready) state_nxt = S_RDATA;
            S_RDATA:  if (i_axi_rdata_valid)  state_nxt = S_DONE;
            S_DONE:                           state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
    end

    // Results only move on the R handshake so they stay valid after done.
    always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            addr_q <= '0;
            data_q <= '0;
            resp_q <= '0;
        end else begin
            if (state == S_IDLE && i_rd_req) begin
                addr_q <= i_rd_addr;
            end
            if (state == S_RDATA && i_axi_rdata_valid) begin
                data_q <= i_axi_rdata;
                resp_q <= i_axi_rresp;
            end
        end
    end

    always_comb begin
        o_rd_req_ready     = 1'b0;
        o_rd_done          = 1'b0;
        o_axi_araddr_valid = 1'b0;
        o_axi_araddr       = '0;
        o_axi_rdata_ready  = 1'b0;
        unique case (state)
            S_IDLE: o_rd_req_ready = 1'b1;
            S_ARADDR: begin
                o_axi_araddr_valid = 1'b1;
                o_axi_araddr       = addr_q;
            end
            S_RDATA: o_axi_rdata_ready = 1'b1;
            S_DONE:  o_rd_done         = 1'b1;
            default: o_rd_req_ready    = 1'b0;
        endcase
    end

    assign o_rd_data     = data_q;
    assign o_rd_resp     = resp_q;
    assign o_rd_err      = |resp_q;
    assign o_axi_arcache = AXI_ARCACHE;
    assign o_axi_arprot  = AXI_ARPROT;

    // Watchdog only flags a stall; the transaction is never aborted.
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
        localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

        logic          busy;
        logic [CW-1:0] wdog_q;

        assign busy = (state == S_ARADDR) || (state == S_RDATA);

        always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
            if (!i_axi_aresetn) begin
                wdog_q <= '0;
            end else if (!busy) begin
                wdog_q <= '0;
            end else if (wdog_q != LIMIT) begin
                wdog_q <= wdog_q + CW'(1);
            end
        end

        assign o_rd_timeout = busy && (wdog_q == LIMIT);
    end else begin : g_no_wdog
        assign o_rd_timeout = 1'b0;
    end

endmodule
